mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1, 2-bit-wide selection path.
- Up to four requesters each present a 2-bit operand and a request line.
- The block grants one requester at a time and drives the 2-bit select.
- It captures the selected operand into a registered output with a valid flag.
- Grants are bounded by a hold limit so no requester can starve the others.
- Sits between the NVBoard switch/button inputs and the LED/segment display logic.

Parameters:
- DATA_W, 2: width of each requester operand and of f.
- MAX_HOLD, 8: maximum consecutive cycles one grant may last. Legal range is 1..255; 1 means rotate every cycle.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, 4: request lines; bit i belongs to requester i.
- x0, input, DATA_W: operand of requester 0.
- x1, input, DATA_W: operand of requester 1.
- x2, input, DATA_W: operand of requester 2.
- x3, input, DATA_W: operand of requester 3.
- gnt, output, 4: one-hot grant, registered; all-zero when idle.
- sel, output, 2: index of the current or last granted requester, registered.
- f, output, DATA_W: captured operand, registered.
- valid, output, 1: f was updated on the most recent edge.

Behaviour:
Reset and state:
- Reset is sampled on the clk edge, so rst=1 takes effect at the next rising edge.
- Reset values: state=IDLE, gnt=4'b0000, sel=0, f=0, valid=0, ptr=0, cnt=0.
- rst=1 overrides everything, including mid-grant; the grant is dropped with no capture.
- States: IDLE, GRANT.
- ptr (2 bits) is the highest-priority index for the next arbitration.

Arbitration (pick):
- Winner = first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3, mod 4.

IDLE:
- If req!=0: next state GRANT, gnt<=onehot(winner), sel<=winner, cnt<=0.
- Grant appears 1 cycle after req is sampled high.

GRANT, on each edge:
- Capture: if req[sel]=1, then f<=x[sel] and valid<=1. Otherwise valid<=0 and f holds.
- Release occurs if req[sel]=0, or if req[sel]=1 and cnt==MAX_HOLD-1. In the timeout case, the capture above still happens on that edge.
- No release: cnt<=cnt+1, and gnt and sel hold.
- On release: ptr<=sel+1 mod 4, and the pick runs with the updated ptr using the current req.
  - If any request is pending: stay in GRANT with the new winner, cnt<=0 (no idle bubble).
  - If none is pending: go to IDLE with gnt<=0; sel holds its last value.

Boundary rules:
- A requester that is released and is the only one still requesting is re-granted immediately, with a fresh cnt.
- If req drops on the same edge as the timeout, it is treated as a drop: no capture that edge.
- Operands are sampled only while granted; x changes on non-granted inputs have no effect.
- In IDLE: valid<=0 each edge and f holds.
- Throughput: one capture per cycle while any request is held. A requester receives at most MAX_HOLD captures per grant.

Decomposition:
- Shared package holds:
  - constants NREQ=4 and SEL_W=2;
  - the state enum {IDLE, GRANT};
  - the localparam default for MAX_HOLD.
- One sub-module, rr_pick: purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
  - Instantiated once and used in both IDLE and GRANT-release paths.
- Operand selection (x[sel]) is done inline in the top block.

Test Plan:
- Reset: rst=1 for 2 edges with req=4'b1111 -> gnt=0, sel=0, f=0, valid=0. After rst falls: gnt=4'b0001 one edge later, then valid=1 with f=x0 on the next edge.
- Single requester: req=4'b0100 with x2=2'b10 held for 3 cycles, then dropped -> gnt=4'b0100 and sel=2. valid=1 with f=2'b10 for 3 edges, then valid=0, gnt=0, state IDLE, ptr=3.
- Rotation: MAX_HOLD=3, req=4'b1111 held, x0..x3 = 0,1,2,3 -> gnt sequence 0001 x3, 0010 x3, 0100 x3, 1000 x3, then back to 0001. f follows 0,0,0,1,1,1,2,2,2,3,3,3 with valid continuously 1.
- Fairness after drop: ptr=0, req=4'b1001, requester 0 drops after 1 cycle -> next gnt=4'b1000 with no IDLE cycle. Requester 0 re-requesting is not granted until requester 3 releases.
- Drop coincident with timeout: MAX_HOLD=2, req[1] falls on the second grant cycle -> only 1 capture, valid=0 on that edge, ptr=2.
- Reset mid-grant: assert rst during gnt=4'b0100 with cnt=1 -> next edge gnt=0, valid=0, f=0, ptr=0. Subsequent req=4'b0110 grants requester 1 first.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin arbiter.
package mux4_rr_arbiter_pkg;

  localparam int unsigned NREQ         = 4;
  localparam int unsigned SEL_W        = 2;
  localparam int unsigned MAX_HOLD_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req : request lines, bit i belongs to requester i
//   ptr : highest-priority index for this search
//   any : at least one request is pending
//   idx : first requesting index searching ptr, ptr+1, ... mod 4
module mux4_rr_arbiter_rr_pick
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic             found;
  logic [SEL_W-1:0] cand;

  // Rotating priority search; the first hit from ptr wins.
  always_comb begin
    any   = |req;
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 select path.
//   clk, rst   : clock, synchronous active-high reset
//   req        : request lines, bit i belongs to requester i
//   x0..x3     : requester operands
//   gnt        : registered one-hot grant, zero when idle
//   sel        : registered index of current/last granted requester
//   f          : registered captured operand
//   valid      : f was updated on the most recent edge
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = 2,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [DATA_W-1:0] x3,
  output logic [NREQ-1:0]   gnt,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] f,
  output logic              valid
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0]  pick_ptr;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] x_sel;
  logic              req_sel;
  logic              timeout;
  logic              release_grant;

  // Operand of the granted requester.
  always_comb begin
    x_sel = x0;
    case (sel)
      2'd0:    x_sel = x0;
      2'd1:    x_sel = x1;
      2'd2:    x_sel = x2;
      default: x_sel = x3;
    endcase
  end

  assign req_sel       = req[sel];
  assign timeout       = (cnt == CNT_W'(MAX_HOLD - 1));
  assign release_grant = !req_sel || timeout;

  // In GRANT the picker only matters on release, where ptr becomes sel+1.
  assign pick_ptr = (state == GRANT) ? (sel + SEL_W'(1)) : ptr;

  mux4_rr_arbiter_rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      f     <= '0;
      valid <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (pick_any) begin
            state <= GRANT;
            gnt   <= onehot(pick_idx);
            sel   <= pick_idx;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (req_sel) begin
            f     <= x_sel;
            valid <= 1'b1;
          end else begin
            valid <= 1'b0;
          end
          if (release_grant) begin
            ptr <= sel + SEL_W'(1);
            // Back-to-back handover avoids an idle bubble.
            if (pick_any) begin
              gnt <= onehot(pick_idx);
              sel <= pick_idx;
              cnt <= '0;
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
